// File: rtl/irq_ctrl.sv
// irq_ctrl: edge/level interrupt controller with fixed priority and 8-bit register port.
// Define IRQ_SYNC_EN to add a two-flop input synchroniser on every irq_in line.
module irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_clr,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vector,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  input  logic [2:0]         address,
  input  logic [7:0]         din,
  input  logic               w_en,
  input  logic               r_en,
  output logic [7:0]         dout
);

  logic [NUM_IRQ-1:0] irq_s;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1;
  logic [NUM_IRQ-1:0] sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq_in;
`endif

  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] mode;
  logic [NUM_IRQ-1:0] prev_in;
  logic               gen;
  logic [VEC_W-1:0]   in_service;
  logic               in_svc_valid;

  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] vec_oh;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] pend_set;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [NUM_IRQ-1:0] pend_nx;
  logic [NUM_IRQ-1:0] mask_nx;
  logic [NUM_IRQ-1:0] mode_nx;
  logic [VEC_W-1:0]   sel_idx;
  logic [5:0]         wr_sel;
  logic               wr_ctrl;
  logic               ack_fire;
  logic               eoi_fire;
  logic [15:0]        pend_w;
  logic [15:0]        mask_w;
  logic [15:0]        mode_w;
  logic [7:0]         rd_data;

  assign active   = pend & mask;
  assign ack_fire = irq_ack & irq_req;
  assign eoi_fire = irq_eoi & in_svc_valid & ~ack_fire;

  always_comb begin
    wr_sel  = '0;
    wr_ctrl = 1'b0;
    if (w_en) begin
      if (address < 3'd6)
        wr_sel[address] = 1'b1;
      wr_ctrl = (address == 3'd7);
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (active[i])
        sel_idx = VEC_W'(i);
  end

  always_comb begin
    vec_oh  = '0;
    w1c     = '0;
    mask_nx = mask;
    mode_nx = mode;
    for (int i = 0; i < NUM_IRQ; i++) begin
      vec_oh[i] = (irq_vector == VEC_W'(i));
      w1c[i]    = wr_sel[i / 8] & din[i % 8];
      if (wr_sel[2 + i / 8])
        mask_nx[i] = din[i % 8];
      if (wr_sel[4 + i / 8])
        mode_nx[i] = din[i % 8];
    end
  end

  // Edge channels need a rising edge; level channels set on every high cycle.
  // Setting is ORed in last so it overrides a same-cycle clear.
  assign pend_set = irq_s & ~(mode & prev_in);
  assign pend_clr = w1c | (ack_fire ? (vec_oh & mode) : '0);
  assign pend_nx  = (pend & ~pend_clr) | pend_set;

  always_comb begin
    pend_w = '0;
    mask_w = '0;
    mode_w = '0;
    pend_w[NUM_IRQ-1:0] = pend;
    mask_w[NUM_IRQ-1:0] = mask;
    mode_w[NUM_IRQ-1:0] = mode;
  end

  always_comb begin
    rd_data = '0;
    case (address)
      3'd0:    rd_data = pend_w[7:0];
      3'd1:    rd_data = pend_w[15:8];
      3'd2:    rd_data = mask_w[7:0];
      3'd3:    rd_data = mask_w[15:8];
      3'd4:    rd_data = mode_w[7:0];
      3'd5:    rd_data = mode_w[15:8];
      3'd6:    rd_data = {in_svc_valid, 7'(in_service)};
      default: rd_data = {7'h00, gen};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend         <= '0;
      mask         <= '0;
      mode         <= '0;
      prev_in      <= '0;
      gen          <= 1'b0;
      in_service   <= '0;
      in_svc_valid <= 1'b0;
      irq_req      <= 1'b0;
      irq_vector   <= '0;
      irq_clr      <= '0;
      dout         <= '0;
    end else begin
      prev_in <= irq_s;
      pend    <= pend_nx;
      mask    <= mask_nx;
      mode    <= mode_nx;
      if (wr_ctrl)
        gen <= din[0];
      irq_req <= ~ack_fire & gen & (|active) & ~in_svc_valid;
      // Vector freezes while a channel is in service.
      if (!in_svc_valid && (|active))
        irq_vector <= sel_idx;
      irq_clr <= ack_fire ? vec_oh : '0;
      if (ack_fire) begin
        in_service   <= irq_vector;
        in_svc_valid <= 1'b1;
      end else if (eoi_fire) begin
        in_svc_valid <= 1'b0;
      end
      if (r_en)
        dout <= rd_data;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: register table, directed corner sequences and random traffic
// checked against a behavioural reference model of irq_ctrl.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] irq_clr;
  logic       irq_req;
  logic [3:0] irq_vector;
  logic       irq_ack;
  logic       irq_eoi;
  logic [2:0] address;
  logic [7:0] din;
  logic [7:0] dout;
  logic       w_en;
  logic       r_en;

  logic [11:0] c_in;
  logic [11:0] c_clr;
  logic        c_req;
  logic [3:0]  c_vec;
  logic        c_ack;
  logic        c_eoi;
  logic [2:0]  c_addr;
  logic [7:0]  c_din;
  logic [7:0]  c_dout;
  logic        c_wen;
  logic        c_ren;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] m_pend, m_mask, m_mode, m_prev, m_clr, m_dout;
  logic       m_gen, m_svc, m_req;
  logic [3:0] m_vec, m_srv;
  logic [7:0] cur_in;
  logic [7:0] v;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  irq_ctrl dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_clr(irq_clr),
    .irq_req(irq_req), .irq_vector(irq_vector), .irq_ack(irq_ack),
    .irq_eoi(irq_eoi), .address(address), .din(din), .w_en(w_en),
    .r_en(r_en), .dout(dout)
  );

  irq_ctrl #(.NUM_IRQ(12), .VEC_W(4)) dut12 (
    .clk(clk), .rst(rst), .irq_in(c_in), .irq_clr(c_clr),
    .irq_req(c_req), .irq_vector(c_vec), .irq_ack(c_ack),
    .irq_eoi(c_eoi), .address(c_addr), .din(c_din), .w_en(c_wen),
    .r_en(c_ren), .dout(c_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] x);
    for (int i = 0; i < 8; i++)
      if (x[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0; m_clr = 0;
    m_dout = 0; m_gen = 0; m_svc = 0; m_req = 0; m_vec = 0; m_srv = 0;
  endtask

  task automatic model_step(input logic [7:0] in, input bit ack, input bit eoi,
                            input logic [2:0] a, input logic [7:0] d,
                            input bit w, input bit r);
    logic [7:0] act, np, rv;
    int sel;
    bit af, ef, s, c;
    logic [3:0] nvec;
    act = m_pend & m_mask;
    sel = lowest(act);
    af = ack && m_req;
    ef = eoi && m_svc && !af;
    case (a)
      3'd0: rv = m_pend;
      3'd2: rv = m_mask;
      3'd4: rv = m_mode;
      3'd6: rv = {m_svc, 3'b000, m_srv};
      3'd7: rv = {7'b0, m_gen};
      default: rv = 8'h00;
    endcase
    for (int i = 0; i < 8; i++) begin
      s = m_mode[i] ? (in[i] && !m_prev[i]) : in[i];
      c = (w && a == 3'd0 && d[i]) || (af && int'(m_vec) == i && m_mode[i]);
      np[i] = s ? 1'b1 : (c ? 1'b0 : m_pend[i]);
    end
    nvec = (!m_svc && sel >= 0) ? 4'(sel) : m_vec;
    m_clr = af ? (8'h01 << m_vec) : 8'h00;
    if (r) m_dout = rv;
    m_req = !af && m_gen && act != 0 && !m_svc;
    if (af) begin
      m_srv = m_vec;
      m_svc = 1'b1;
    end else if (ef) begin
      m_svc = 1'b0;
    end
    if (w) begin
      if (a == 3'd2) m_mask = d;
      if (a == 3'd4) m_mode = d;
      if (a == 3'd7) m_gen = d[0];
    end
    m_vec = nvec;
    m_pend = np;
    m_prev = in;
  endtask

  task automatic tick(input logic [7:0] in, input bit ack, input bit eoi,
                      input logic [2:0] a, input logic [7:0] d,
                      input bit w, input bit r);
    irq_in = in; irq_ack = ack; irq_eoi = eoi;
    address = a; din = d; w_en = w; r_en = r;
    model_step(in, ack, eoi, a, d, w, r);
    @(posedge clk);
    @(negedge clk);
    chk("req", irq_req, m_req);
    chk("vec", irq_vector, m_vec);
    chk("clr", irq_clr, m_clr);
    chk("dout", dout, m_dout);
  endtask

  task automatic idle();
    tick(cur_in, 0, 0, 3'd0, 8'h00, 0, 0);
  endtask

  task automatic ack_t();
    tick(cur_in, 1, 0, 3'd0, 8'h00, 0, 0);
  endtask

  task automatic eoi_t();
    tick(cur_in, 0, 1, 3'd0, 8'h00, 0, 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    tick(cur_in, 0, 0, a, d, 1, 0);
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] q);
    tick(cur_in, 0, 0, a, 8'h00, 0, 1);
    q = dout;
  endtask

  task automatic tick12(input logic [11:0] in, input logic [2:0] a,
                        input logic [7:0] d, input bit w, input bit r);
    c_in = in; c_addr = a; c_din = d; c_wen = w; c_ren = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    cur_in = 0;
    irq_in = 0; irq_ack = 0; irq_eoi = 0; address = 0;
    din = 0; w_en = 0; r_en = 0;
    c_in = 0; c_ack = 0; c_eoi = 0; c_addr = 0;
    c_din = 0; c_wen = 0; c_ren = 0;
    model_reset();
    tbl[0] = '{3'd2, 8'hA5, 8'hA5};
    tbl[1] = '{3'd3, 8'hFF, 8'h00};
    tbl[2] = '{3'd4, 8'h3C, 8'h3C};
    tbl[3] = '{3'd5, 8'h12, 8'h00};
    tbl[4] = '{3'd7, 8'hFE, 8'h00};
    tbl[5] = '{3'd7, 8'hFF, 8'h01};
    tbl[6] = '{3'd6, 8'hFF, 8'h00};
    tbl[7] = '{3'd0, 8'hFF, 8'h00};
    tbl[8] = '{3'd1, 8'hFF, 8'h00};
    tbl[9] = '{3'd2, 8'h00, 8'h00};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst_req", irq_req, 0);
    chk("rst_clr", irq_clr, 0);
    chk("rst_vec", irq_vector, 0);
    chk("rst_dout", dout, 0);

    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, v);
      chk($sformatf("tbl%0d", i), v, tbl[i].exp);
    end
    idle();
    chk("dout_hold", dout, 8'h00);
    rd(3'd4, v);
    idle();
    chk("dout_hold2", dout, 8'h3C);

    wr(3'd4, 8'hFF); wr(3'd2, 8'hFF); wr(3'd7, 8'h01);
    cur_in = 8'h24; idle();
    cur_in = 8'h00; idle();
    chk("ep_req", irq_req, 1);
    chk("ep_vec", irq_vector, 2);
    ack_t();
    chk("ep_clr", irq_clr, 8'h04);
    chk("ep_req_drop", irq_req, 0);
    idle();
    chk("ep_clr_1cyc", irq_clr, 0);
    rd(3'd0, v); chk("ep_pend", v, 8'h20);
    rd(3'd6, v); chk("ep_status", v, 8'h82);
    ack_t();
    chk("ep_ack_ignored", irq_clr, 0);
    eoi_t(); idle();
    chk("ep_vec5", irq_vector, 5);
    chk("ep_req5", irq_req, 1);
    ack_t(); eoi_t();

    wr(3'd4, 8'h00); wr(3'd2, 8'h08);
    cur_in = 8'h08; idle(); idle();
    chk("lv_req", irq_req, 1);
    chk("lv_vec", irq_vector, 3);
    ack_t();
    chk("lv_clr", irq_clr, 8'h08);
    idle(); eoi_t(); idle();
    chk("lv_reassert", irq_req, 1);
    chk("lv_vec3", irq_vector, 3);
    cur_in = 8'h00;
    wr(3'd0, 8'h08); idle();
    chk("lv_req_off", irq_req, 0);
    rd(3'd0, v); chk("lv_pend", v, 8'h00);
    chk("lv_req_stay", irq_req, 0);

    wr(3'd7, 8'h00); wr(3'd4, 8'hFF); wr(3'd2, 8'h01);
    cur_in = 8'h01; idle();
    cur_in = 8'h00; idle(); idle();
    chk("mg_gen0", irq_req, 0);
    wr(3'd7, 8'h01); idle();
    chk("mg_gen1", irq_req, 1);
    wr(3'd2, 8'h00); idle();
    chk("mg_mask0", irq_req, 0);
    rd(3'd0, v); chk("mg_pend", v, 8'h01);

    wr(3'd0, 8'h01);
    cur_in = 8'h02; wr(3'd0, 8'h02);
    cur_in = 8'h00; rd(3'd0, v);
    chk("w1c_set_wins", v, 8'h02);
    wr(3'd0, 8'h02);

    wr(3'd2, 8'hFF); wr(3'd4, 8'hFF);
    cur_in = 8'h01; idle();
    cur_in = 8'h00; idle(); ack_t();
    cur_in = 8'h05; idle();
    cur_in = 8'h00; idle();
    rd(3'd0, v); chk("pre_rst_pend", v, 8'h05);
    rd(3'd6, v); chk("pre_rst_status", v, 8'h80);
    rst = 1'b0;
    #1;
    chk("mrst_req", irq_req, 0);
    chk("mrst_clr", irq_clr, 0);
    chk("mrst_vec", irq_vector, 0);
    chk("mrst_dout", dout, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      chk($sformatf("mrst_reg%0d", a), v, 0);
    end

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] rin;
      rin = 8'($urandom) & 8'($urandom) & 8'($urandom);
      tick(rin, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)), 8'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
    end

    tick12(12'h000, 3'd5, 8'hFF, 1, 0);
    tick12(12'h000, 3'd3, 8'hFF, 1, 0);
    tick12(12'h000, 3'd7, 8'h01, 1, 0);
    tick12(12'h000, 3'd3, 8'h00, 0, 1);
    chk("n12_maskh", c_dout, 8'h0F);
    tick12(12'h800, 3'd0, 8'h00, 0, 0);
    tick12(12'h000, 3'd0, 8'h00, 0, 0);
    chk("n12_req", c_req, 1);
    chk("n12_vec", c_vec, 11);
    tick12(12'h000, 3'd1, 8'h00, 0, 1);
    chk("n12_pendh", c_dout, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller that replaces the fixed four-line interrupt/clear wiring between peripherals and the CPU.
- Accepts NUM_IRQ peripheral request lines, each configurable as edge- or level-sensitive.
- Latches pending bits, applies an enable mask and a global enable, and resolves fixed priority (lowest index wins) into a single request/vector to the CPU.
- Software access is through the 8-bit data-memory/IO bus; per-channel clear pulses go back to the peripherals.

Parameters:
- NUM_IRQ, 8, number of interrupt channels, legal range 1..16.
- VEC_W, 4, vector width; must satisfy 2^VEC_W >= NUM_IRQ.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- irq_in  input  NUM_IRQ  peripheral request lines.
- irq_clr  output  NUM_IRQ  one-cycle clear pulse to the acknowledged peripheral.
- irq_req  output  1  request to CPU.
- irq_vector  output  VEC_W  index of the highest-priority active channel.
- irq_ack  input  1  one-cycle CPU acknowledge.
- irq_eoi  input  1  one-cycle CPU end-of-interrupt.
- address  input  3  register offset; base decode is external.
- din  input  8  write data.
- w_en  input  1  write strobe.
- r_en  input  1  read strobe.
- dout  output  8  read data.

Behaviour:
- Reset (rst low, asynchronous): all registers, prev_in, in_service and in_svc_valid clear to 0. Outputs irq_req=0, irq_vector=0, irq_clr=0, dout=0.
- Register map (bits at or above NUM_IRQ read 0 and ignore writes):
  - 0 PEND_L, 1 PEND_H: read; write-1-to-clear.
  - 2 MASK_L, 3 MASK_H: read/write; 1 = enabled.
  - 4 MODE_L, 5 MODE_H: read/write; 1 = edge, 0 = level.
  - 6 STATUS: read-only; bit7 = in_svc_valid, bits[VEC_W-1:0] = in_service.
  - 7 CTRL: read/write; bit0 = global enable GEN.
- Reads: dout is registered and valid the cycle after r_en; it holds its value when r_en is low.
- Pending set rules:
  - Edge channel: pending sets on the cycle after irq_in[i]=1 while prev_in[i]=0. prev_in resets to 0, so a line already high at reset release counts as an edge.
  - Level channel: pending is forced to 1 every cycle irq_in[i]=1.
- Set/clear conflicts: when a set and a clear (W1C or ack) hit the same bit in the same cycle, set wins.
- Active set: active = pending & mask. The selected channel is the lowest index with active=1.
- irq_req (registered, one cycle after the condition): GEN & |active & ~in_svc_valid.
- irq_vector: registered selected index, updated whenever in_svc_valid=0. When no channel is active it holds its last value.
- Ack: irq_ack while irq_req=1. Next edge:
  - in_service <= irq_vector and in_svc_valid <= 1.
  - If the channel is edge mode, its pending bit clears.
  - irq_clr[irq_vector] pulses for exactly one cycle; irq_req drops in the same cycle.
- Ignored strobes: irq_ack while irq_req=0 has no effect. irq_eoi while in_svc_valid=0 has no effect.
- EOI: irq_eoi clears in_svc_valid. irq_req may reassert on the following cycle.
- Simultaneous ack and eoi: ack takes precedence and eoi is dropped.
- Masking and GEN: clearing GEN or a mask bit never clears pending; it only suppresses irq_req from the next cycle.
- Level channels: if the line stays high after ack, pending re-sets immediately. Software must silence the source before issuing eoi.
- No nesting: while in_svc_valid=1, no new irq_req is raised regardless of priority.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: each irq_in bit passes through a two-flop synchroniser (reset 0) before edge/level detection. Input-to-pending latency becomes 3 cycles.
- Undefined: irq_in is sampled directly and must already be synchronous to clk. Input-to-pending latency is 1 cycle.

Test Plan:
- Reset: drive rst low mid-operation with pending=0x05 and in_svc_valid=1, then release -> all registers read 0, irq_req=0, irq_clr=0.
- Edge priority: MODE_L=0xFF, MASK_L=0xFF, CTRL=1; pulse irq_in[5] and irq_in[2] in the same cycle -> irq_vector=2 and irq_req=1. Ack -> irq_clr=0x04 for one cycle and PEND_L=0x20. Eoi -> irq_vector=5 and irq_req=1.
- Level re-assert: MODE_L=0x00, MASK_L=0x08; hold irq_in[3] high, ack, then eoi -> irq_req reasserts with vector 3. Drop irq_in[3], write PEND_L=0x08 -> PEND_L=0 and irq_req stays 0.
- Mask/GEN: pending=0x01 with CTRL=0 -> irq_req=0; write CTRL=1 -> irq_req=1 within 2 cycles. Write MASK_L=0 -> irq_req=0 and PEND_L still reads 0x01.
- W1C collision: edge on irq_in[1] in the same cycle as a write of PEND_L=0x02 -> PEND_L reads 0x02 (set wins).
- NUM_IRQ=12: edge on irq_in[11] -> PEND_H=0x08 and irq_vector=11; writes to MASK_H bits 7:4 read back 0.
